alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute-stage ALU that consumes the 4-bit alu_ctrl code ({funct7[5], funct3})
//  produced by the ALU controller, together with both operands.
//  - Non-shift ops complete in 1 cycle.
//  - Shifts use an iterative 1-bit-per-cycle shifter, avoiding a barrel shifter.
//  - Valid/ready handshakes on both sides; the registered result feeds writeback
//    and branch resolution.
// PARAMETERS
//  REG_DATA_WIDTH  32  Operand/result width. Power of two, >= 8.
//                      SHW = log2(REG_DATA_WIDTH) is a derived localparam.
// PORTS
//  clk        in   1       Clock; all state changes on the rising edge.
//  reset      in   1       Synchronous, active-high reset.
//  in_valid   in   1       Operation request valid.
//  in_ready   out  1       Unit can accept a request.
//  alu_ctrl   in   4       Operation code {funct7[5], funct3}.
//  op_a       in   RDW     Operand A (rs1).
//  op_b       in   RDW     Operand B (rs2/imm). Shift amount is op_b[SHW-1:0].
//  out_valid  out  1       result/zero valid.
//  out_ready  in   1       Consumer accepts the result.
//  result     out  RDW     Operation result.
//  zero       out  1       (result == 0); qualified by out_valid.
// BEHAVIOUR
//  Reset: state=IDLE, out_valid=0, result=0, zero=1, shift counter=0.
//   in_ready is forced 0 while reset is high.
//   Reset aborts any in-flight operation; its result is discarded.
//  FSM states: IDLE, SHIFT, DONE.
//   in_ready = (state==IDLE) & ~reset.
//   out_valid = (state==DONE).
//  Accept: in_valid & in_ready at a rising edge.
//   alu_ctrl, op_a and op_b are captured at accept.
//   Later input changes are ignored until the next accept.
//  Decode (x = don't care):
//   0000 ADD   1000 SUB   x001 SLL   x010 SLT   x011 SLTU
//   x100 XOR   0101 SRL   1101 SRA   x110 OR    x111 AND
//   All 16 codes are defined.
//  Arithmetic:
//   - ADD/SUB wrap modulo 2^RDW; no carry/overflow outputs.
//   - SLT is a signed compare, SLTU unsigned; result is 1 or 0, zero-extended.
//  Non-shift op, or any shift with shamt==0:
//   - IDLE->DONE at accept; result registered at the same edge.
//   - Latency 1: out_valid high in the cycle after the accept.
//   - A shamt==0 shift returns op_a.
//  Shift op with shamt>=1:
//   - At accept: IDLE->SHIFT, acc=op_a, cnt=shamt.
//   - Each SHIFT cycle moves acc 1 bit and decrements cnt.
//     SLL/SRL shift in 0; SRA shifts in acc[RDW-1].
//   - On the edge where cnt reaches 0, SHIFT->DONE and result=final acc.
//   - Latency = shamt cycles (max RDW-1); in_ready=0 throughout.
//  DONE:
//   - result and zero are held stable until out_valid & out_ready.
//   - At that edge: DONE->IDLE, out_valid->0.
//   - No same-cycle re-accept; max throughput is 1 op per 2 cycles.
//  out_ready is ignored outside DONE.
//   in_valid without in_ready holds no state in this unit.
// TESTING
//  1. ADD 0x7FFFFFFF+0x1 (ctrl 0000) -> result 0x80000000, zero=0,
//     out_valid exactly 1 cycle after accept.
//  2. SUB 5-5 (ctrl 1000) -> result 0, zero=1;
//     same operands with ctrl 0000 -> result 10.
//  3. SRA op_a=0x80000000, op_b=0x24 (shamt 4, upper bits ignored, ctrl 1101)
//     -> 0xF8000000 after 4 cycles, in_ready=0 throughout;
//     SRL same operands -> 0x08000000.
//  4. SLT 0xFFFFFFFF vs 0x1 -> 1; SLTU same operands -> 0;
//     SLL shamt 0 -> op_a with latency 1.
//  5. out_ready held 0 for 3 cycles in DONE -> result stable, in_ready=0;
//     handshake -> in_ready=1 in the next cycle, next op accepted.
//  6. reset pulsed mid SLL with shamt 31 -> out_valid=0, state=IDLE,
//     in_ready=1 in the first cycle after reset falls; no stale result appears.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//   Execute-stage ALU driven by the 4-bit alu_ctrl code {funct7[5], funct3}.
//   Non-shift operations (and shifts by zero) produce a registered result one
//   cycle after accept. Shifts by a non-zero amount run on an iterative
//   1-bit-per-cycle shifter, so no barrel shifter is built.
//
// Ports
//   clk        in   1    clock, rising edge
//   reset      in   1    synchronous, active-high reset
//   in_valid   in   1    request valid
//   in_ready   out  1    unit can accept a request (IDLE and not in reset)
//   alu_ctrl   in   4    {funct7[5], funct3}
//   op_a       in   RDW  operand A (rs1)
//   op_b       in   RDW  operand B (rs2/imm); shift amount is op_b[SHW-1:0]
//   out_valid  out  1    result/zero valid (DONE state)
//   out_ready  in   1    consumer accepts result
//   result     out  RDW  registered result
//   zero       out  1    result == 0
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [3:0]                alu_ctrl,
  input  logic [REG_DATA_WIDTH-1:0] op_a,
  input  logic [REG_DATA_WIDTH-1:0] op_b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [REG_DATA_WIDTH-1:0] result,
  output logic                      zero
);

  localparam int RDW = REG_DATA_WIDTH;
  localparam int SHW = $clog2(RDW);
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // result_q doubles as the shift accumulator while in SHIFT.
  logic [RDW-1:0]   result_q, result_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             dir_right_q, dir_right_d;
  logic             arith_q, arith_d;

  logic             accept;
  logic [2:0]       funct3;
  logic             f7;
  logic [SHW-1:0]   shamt;
  logic             is_shift;
  logic             shift_start;
  logic [RDW-1:0]   alu_out;
  logic [RDW-1:0]   shift_step;

  // ---------------- decode ----------------
  assign funct3      = alu_ctrl[2:0];
  assign f7          = alu_ctrl[3];
  assign shamt       = op_b[SHW-1:0];
  assign is_shift    = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign accept      = in_valid & in_ready;
  // Shift by zero takes the single-cycle path and returns op_a unchanged.
  assign shift_start = accept & is_shift & (shamt != '0);

  // ---------------- single-cycle ALU ----------------
  always_comb begin
    alu_out = '0;
    case (funct3)
      3'b000:  alu_out = f7 ? (op_a - op_b) : (op_a + op_b);
      3'b001,
      3'b101:  alu_out = op_a;
      3'b010:  alu_out = {{(RDW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      3'b011:  alu_out = {{(RDW-1){1'b0}}, (op_a < op_b)};
      3'b100:  alu_out = op_a ^ op_b;
      3'b110:  alu_out = op_a | op_b;
      3'b111:  alu_out = op_a & op_b;
      default: alu_out = '0;
    endcase
  end

  // One bit of shift per cycle; SRA replicates the current sign bit.
  assign shift_step = dir_right_q
                    ? {(arith_q & result_q[RDW-1]), result_q[RDW-1:1]}
                    : {result_q[RDW-2:0], 1'b0};

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = shift_start ? S_SHIFT : S_DONE;
      S_SHIFT: if (cnt_q == CNT_ONE) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (state_q == S_IDLE) & ~reset;
    out_valid = (state_q == S_DONE);
  end

  // ---------------- datapath ----------------
  always_comb begin
    result_d    = result_q;
    cnt_d       = cnt_q;
    dir_right_d = dir_right_q;
    arith_d     = arith_q;
    if (accept) begin
      if (shift_start) begin
        result_d    = op_a;
        cnt_d       = shamt;
        dir_right_d = funct3[2];
        arith_d     = f7;
      end else begin
        result_d = alu_out;
        cnt_d    = '0;
      end
    end else if (state_q == S_SHIFT) begin
      result_d = shift_step;
      cnt_d    = cnt_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      cnt_q       <= '0;
      dir_right_q <= 1'b0;
      arith_q     <= 1'b0;
    end else begin
      result_q    <= result_d;
      cnt_q       <= cnt_d;
      dir_right_q <= dir_right_d;
      arith_q     <= arith_d;
    end
  end

  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_exec_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_exec_unit
//   Self-checking bench: directed corner cases followed by randomized
//   operations compared against a behavioural ALU model.
// ---------------------------------------------------------------------------
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.REG_DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: RISC-V ALU semantics on 32-bit operands.
  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a,
                                          input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    case (c[2:0])
      3'd0: return c[3] ? (a - b) : (a + b);
      3'd1: return a << sh;
      3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return c[3] ? 32'($signed(a) >>> sh) : (a >> sh);
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  // Number of cycles spent shifting before the result becomes valid.
  function automatic int ref_shift_cycles(input logic [3:0] c, input logic [31:0] b);
    if (c[1:0] == 2'b01) return int'(b[4:0]);
    return 0;
  endfunction

  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] exp;
    logic [31:0] held;
    int          exp_cyc;
    int          cyc;
    exp     = ref_alu(c, a, b);
    exp_cyc = ref_shift_cycles(c, b);
    check("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    alu_ctrl = c;
    op_a     = a;
    op_b     = b;
    @(posedge clk); #1;
    // Scramble inputs: the unit must have captured them at accept.
    in_valid = 1'b0;
    alu_ctrl = 4'($urandom);
    op_a     = $urandom;
    op_b     = $urandom;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      check("in_ready_busy", {31'd0, in_ready}, 32'd0);
      out_ready = 1'($urandom);   // ignored outside DONE
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    check("latency", cyc, exp_cyc);
    check("result", result, exp);
    check("zero", {31'd0, zero}, {31'd0, (exp == 32'd0)});
    check("in_ready_done", {31'd0, in_ready}, 32'd0);
    $display("op ctrl=%b a=0x%08h b=0x%08h result=0x%08h exp=0x%08h cyc=%0d",
             c, a, b, result, exp, cyc);
    held = result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_result", result, held);
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [3:0]  rc;
    logic [31:0] ra;
    logic [31:0] rb;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    alu_ctrl  = 4'd0;
    op_a      = 32'd0;
    op_b      = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd1);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);

    // Directed cases
    run_op(4'b0000, 32'h7FFFFFFF, 32'h00000001, 0);  // ADD overflow wrap
    run_op(4'b1000, 32'd5, 32'd5, 0);                // SUB -> zero
    run_op(4'b0000, 32'd5, 32'd5, 0);                // ADD -> 10
    run_op(4'b1101, 32'h80000000, 32'h00000024, 0);  // SRA by 4
    run_op(4'b0101, 32'h80000000, 32'h00000024, 0);  // SRL by 4
    run_op(4'b0010, 32'hFFFFFFFF, 32'h00000001, 0);  // SLT
    run_op(4'b0011, 32'hFFFFFFFF, 32'h00000001, 0);  // SLTU
    run_op(4'b0001, 32'hDEADBEEF, 32'h00000020, 0);  // SLL shamt 0
    run_op(4'b0100, 32'h12345678, 32'h0F0F0F0F, 3);  // XOR, held 3 cycles
    run_op(4'b1001, 32'h00000001, 32'h0000001F, 0);  // SLL by 31 (max)
    run_op(4'b1110, 32'h00F000F0, 32'h0F000F00, 0);  // OR
    run_op(4'b0111, 32'hFF00FF00, 32'h0FF00FF0, 0);  // AND

    // Reset in the middle of a long shift
    in_valid = 1'b1;
    alu_ctrl = 4'b0001;
    op_a     = 32'h00000003;
    op_b     = 32'd31;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_zero", {31'd0, zero}, 32'd1);
    begin
      int stale;
      stale = 0;
      repeat (40) begin
        @(posedge clk); #1;
        if (out_valid) stale++;
      end
      check("no_stale_result", stale, 0);
    end

    // Randomized operations
    for (int n = 0; n < 200; n++) begin
      rc = 4'($urandom);
      case ($urandom_range(0, 3))
        0:       ra = 32'h80000000;
        1:       ra = 32'hFFFFFFFF;
        2:       ra = 32'd0;
        default: ra = $urandom;
      endcase
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op(rc, ra, rb, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
